// File: rtl/bht_outcome_demux.sv
`default_nettype none
// ============================================================================
// Module   : bht_outcome_demux
// Purpose  : Branch history table of NUM_ENTRIES saturating counters.
//            A resolved branch outcome is steered to one channel. That
//            channel's counter is trained, and a registered one-hot strobe
//            (ENABLE) and the routed outcome (OUT) are emitted one cycle
//            later. A registered lookup port returns the counter at
//            LOOKUP_ADDR (PRED_STATE) and its MSB (PREDICT). A same-cycle
//            update to the looked-up channel is forwarded to the lookup.
// Ports    : CLOCK, RESET (sync, active-high)
//            UPDATE_VALID, UPDATE_ADDR[IDX_W], OUTCOME  - training request
//            LOOKUP_ADDR[IDX_W]                         - prediction index
//            ENABLE[NUM_ENTRIES], OUT[NUM_ENTRIES]      - routed update
//            PREDICT, PRED_STATE[CTR_W]                 - prediction
// Revision : 1.0 - initial release
// ============================================================================
module bht_outcome_demux #(
    parameter int NUM_ENTRIES = 8,
    parameter int CTR_W       = 2,
    parameter int IDX_W       = $clog2(NUM_ENTRIES)
) (
    input  logic                   CLOCK,
    input  logic                   RESET,
    input  logic                   UPDATE_VALID,
    input  logic [IDX_W-1:0]       UPDATE_ADDR,
    input  logic                   OUTCOME,
    input  logic [IDX_W-1:0]       LOOKUP_ADDR,
    output logic [NUM_ENTRIES-1:0] ENABLE,
    output logic [NUM_ENTRIES-1:0] OUT,
    output logic                   PREDICT,
    output logic [CTR_W-1:0]       PRED_STATE
);

    localparam logic [CTR_W-1:0]       c_CTR_MAX  = {CTR_W{1'b1}};
    // Weakly not-taken: 0 for a 1-bit counter, 01 for 2 bits, 011 for 3 bits.
    localparam logic [CTR_W-1:0]       c_CTR_INIT = CTR_W'((1 << (CTR_W - 1)) - 1);
    localparam logic [NUM_ENTRIES-1:0] c_ONE      = NUM_ENTRIES'(1);

    logic [CTR_W-1:0]       w_ctr [NUM_ENTRIES];
    logic [CTR_W-1:0]       w_cur;
    logic [CTR_W-1:0]       w_next;
    logic [NUM_ENTRIES-1:0] w_sel;
    logic                   w_bypass;

    logic [NUM_ENTRIES-1:0] r_enable;
    logic [NUM_ENTRIES-1:0] r_out;
    logic [CTR_W-1:0]       r_pred_state;

    // Trained value of the addressed counter; one shared incrementer is enough
    // because only one channel can be updated per cycle.
    assign w_cur = w_ctr[UPDATE_ADDR];

    always_comb begin
        w_next = w_cur;
        if (OUTCOME) begin
            if (w_cur != c_CTR_MAX) begin
                w_next = w_cur + CTR_W'(1);
            end
        end else begin
            if (w_cur != '0) begin
                w_next = w_cur - CTR_W'(1);
            end
        end
    end

    assign w_sel    = c_ONE << UPDATE_ADDR;
    assign w_bypass = UPDATE_VALID && (UPDATE_ADDR == LOOKUP_ADDR);

    generate
        for (genvar i = 0; i < NUM_ENTRIES; i++) begin : g_ctr
            logic [CTR_W-1:0] r_ctr;

            always_ff @(posedge CLOCK) begin
                if (RESET) begin
                    r_ctr <= c_CTR_INIT;
                end else if (UPDATE_VALID && w_sel[i]) begin
                    r_ctr <= w_next;
                end
            end

            assign w_ctr[i] = r_ctr;
        end
    endgenerate

    always_ff @(posedge CLOCK) begin
        if (RESET) begin
            r_enable     <= '0;
            r_out        <= '0;
            r_pred_state <= c_CTR_INIT;
        end else begin
            r_enable     <= UPDATE_VALID ? w_sel : '0;
            r_out        <= (UPDATE_VALID && OUTCOME) ? w_sel : '0;
            // Forward the freshly trained value so the lookup never sees a
            // stale counter for a channel updated on the same edge.
            r_pred_state <= w_bypass ? w_next : w_ctr[LOOKUP_ADDR];
        end
    end

    assign ENABLE     = r_enable;
    assign OUT        = r_out;
    assign PRED_STATE = r_pred_state;
    assign PREDICT    = r_pred_state[CTR_W-1];

endmodule
`default_nettype wire

// File: tb/tb_bht_outcome_demux.sv
`default_nettype none
// ============================================================================
// Module   : tb_bht_outcome_demux
// Purpose  : Scoreboard bench for bht_outcome_demux. Three configurations
//            (8/2, 2/1, 64/3) each run a directed sequence followed by random
//            traffic. The expected outputs come from an integer reference
//            model and are queued, and a monitor pops and compares them after
//            every rising edge.
// Revision : 1.0 - initial release
// ============================================================================
module tb_bht_outcome_demux;

    typedef struct {
        logic [63:0] en;
        logic [63:0] out;
        int          ps;
        logic        pred;
    } exp_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;
    bit done [3];

    generate
        for (genvar k = 0; k < 3; k++) begin : g_cfg
            localparam int NE   = (k == 0) ? 8 : (k == 1) ? 2 : 64;
            localparam int CW   = (k == 0) ? 2 : (k == 1) ? 1 : 3;
            localparam int IW   = $clog2(NE);
            localparam int CMAX = (1 << CW) - 1;
            localparam int CINI = (1 << (CW - 1)) - 1;

            logic          rst_s = 1'b1;
            logic          uv    = 1'b0;
            logic [IW-1:0] ua    = '0;
            logic          oc    = 1'b0;
            logic [IW-1:0] la    = '0;
            logic [NE-1:0] en;
            logic [NE-1:0] out;
            logic          pred;
            logic [CW-1:0] ps;

            bht_outcome_demux #(
                .NUM_ENTRIES(NE),
                .CTR_W      (CW)
            ) u_dut (
                .CLOCK       (clk),
                .RESET       (rst_s),
                .UPDATE_VALID(uv),
                .UPDATE_ADDR (ua),
                .OUTCOME     (oc),
                .LOOKUP_ADDR (la),
                .ENABLE      (en),
                .OUT         (out),
                .PREDICT     (pred),
                .PRED_STATE  (ps)
            );

            int   model [NE];
            exp_t q [$];

            task automatic chk(input string name, input logic [63:0] got, input logic [63:0] want);
                n_tests++;
                if (got !== want) begin
                    n_fail++;
                    $display("FAIL cfg%0d %s: got %0h expected %0h at %0t", k, name, got, want, $time);
                end
            endtask

            // One cycle of stimulus. The model predicts the outputs after the
            // coming rising edge, and the prediction is pushed to the scoreboard.
            task automatic cyc(input bit r, input bit v, input int a, input bit o, input int l);
                exp_t e;
                int   am;
                int   lm;
                am = a % NE;
                lm = l % NE;
                @(negedge clk);
                rst_s = r;
                uv    = v;
                ua    = IW'(am);
                oc    = o;
                la    = IW'(lm);
                if (r) begin
                    foreach (model[i]) model[i] = CINI;
                    e.en  = '0;
                    e.out = '0;
                    e.ps  = CINI;
                end else begin
                    e.en  = v ? (64'(1) << am) : 64'(0);
                    e.out = (v && o) ? (64'(1) << am) : 64'(0);
                    if (v) begin
                        if (o) model[am] = (model[am] + 1 > CMAX) ? CMAX : model[am] + 1;
                        else   model[am] = (model[am] - 1 < 0)    ? 0    : model[am] - 1;
                    end
                    e.ps = model[lm];
                end
                e.pred = ((e.ps >> (CW - 1)) & 1) != 0;
                q.push_back(e);
            endtask

            always @(posedge clk) begin
                exp_t e;
                #1;
                if (q.size() != 0) begin
                    e = q.pop_front();
                    chk("ENABLE",     64'(en),  e.en);
                    chk("OUT",        64'(out), e.out);
                    chk("PRED_STATE", 64'(ps),  64'(e.ps));
                    chk("PREDICT",    64'(pred), 64'(e.pred));
                    chk("ENABLE_onehot", 64'($countones(en) <= 1), 64'(1));
                end
            end

            initial begin
                foreach (model[i]) model[i] = CINI;
                cyc(1, 0, 0, 0, 0);
                cyc(1, 1, 3, 1, 0);
                // Reset state read back on every channel.
                for (int i = 0; i < 8; i++) cyc(0, 0, 0, 0, i);
                // Single taken update to channel 5, then look it up.
                cyc(0, 1, 5, 1, 0);
                cyc(0, 0, 0, 0, 5);
                cyc(0, 0, 0, 0, 5);
                // Saturation at both ends on channel 3.
                cyc(1, 0, 0, 0, 0);
                for (int i = 0; i < 4; i++) cyc(0, 1, 3, 1, 3);
                for (int i = 0; i < 5; i++) cyc(0, 1, 3, 0, 3);
                cyc(0, 0, 0, 0, 3);
                // Same-edge bypass on channel 2.
                cyc(1, 0, 0, 0, 0);
                cyc(0, 1, 2, 1, 2);
                cyc(0, 0, 0, 0, 2);
                // Update coincident with reset is discarded.
                cyc(0, 1, 6, 1, 6);
                cyc(1, 1, 6, 1, 6);
                cyc(0, 0, 0, 0, 6);
                // Back-to-back updates across and within channels.
                for (int i = 0; i < 8; i++) cyc(0, 1, i, i[0], (i + 1) % 8);
                cyc(0, 1, 1, 1, 1);
                cyc(0, 1, 1, 1, 1);
                // Random traffic with occasional reset and biased lookups.
                for (int n = 0; n < 3000; n++) begin
                    int a;
                    int l;
                    a = int'($urandom_range(NE - 1, 0));
                    l = ($urandom_range(3, 0) == 0) ? a : int'($urandom_range(NE - 1, 0));
                    cyc(($urandom_range(63, 0) == 0), ($urandom_range(9, 0) < 7),
                        a, $urandom_range(1, 0), l);
                end
                cyc(0, 0, 0, 0, 0);
                repeat (2) @(negedge clk);
                chk("scoreboard_drained", 64'(q.size()), 64'(0));
                done[k] = 1'b1;
            end
        end
    endgenerate

    initial begin
        int cycles;
        cycles = 0;
        while (!(done[0] && done[1] && done[2]) && cycles < 60000) begin
            @(posedge clk);
            cycles++;
        end
        n_tests++;
        if (!(done[0] && done[1] && done[2])) begin
            n_fail++;
            $display("FAIL timeout: got %0d cycles without completion, required completion within 60000", cycles);
        end
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/bht_outcome_demux.md
BHT_OUTCOME_DEMUX -- requirements
Module: bht_outcome_demux

Interface
REQ-001 Parameter NUM_ENTRIES, default 8, number of predictor channels; power of two, 2..64.
REQ-002 Parameter CTR_W, default 2, saturating-counter width per channel; 1..4.
REQ-003 Parameter IDX_W, default $clog2(NUM_ENTRIES), address width; derived, never overridden.
REQ-004 CLOCK  input  1  single clock; all state updates on rising edge.
REQ-005 RESET  input  1  synchronous, active-high reset.
REQ-006 UPDATE_VALID  input  1  resolved-branch update request this cycle.
REQ-007 UPDATE_ADDR  input  IDX_W  channel index of the resolved branch.
REQ-008 OUTCOME  input  1  resolved direction: 1 taken, 0 not taken.
REQ-009 LOOKUP_ADDR  input  IDX_W  channel index to predict.
REQ-010 ENABLE  output  NUM_ENTRIES  registered one-hot update strobe per channel.
REQ-011 OUT  output  NUM_ENTRIES  registered routed outcome per channel.
REQ-012 PREDICT  output  1  registered prediction for LOOKUP_ADDR; 1 = taken.
REQ-013 PRED_STATE  output  CTR_W  registered counter value behind PREDICT.

Function
REQ-014 Each channel holds one CTR_W-bit unsigned saturating counter.
REQ-015 Update on edge with UPDATE_VALID=1: counter[UPDATE_ADDR] increments if OUTCOME=1, decrements if OUTCOME=0.
REQ-016 Saturation: the counter holds at 2^CTR_W-1 on taken and at 0 on not-taken; no wrap-around.
REQ-017 Only the addressed channel changes; all other counters hold.
REQ-018 UPDATE_VALID=0: no counter changes, regardless of UPDATE_ADDR/OUTCOME.
REQ-019 ENABLE[i] is 1 for exactly one cycle after an edge with UPDATE_VALID=1 and UPDATE_ADDR=i; otherwise 0; latency 1 cycle.
REQ-020 OUT[i] equals the sampled OUTCOME when ENABLE[i]=1; otherwise 0.
REQ-021 ENABLE is all-zero after any edge with UPDATE_VALID=0; there is no default channel.
REQ-022 Back-to-back updates (UPDATE_VALID high on consecutive cycles) are each applied and produce one ENABLE pulse per cycle.
REQ-023 Back-to-back updates to the same channel accumulate, e.g. two taken from 1 give 3 at CTR_W=2.
REQ-024 PRED_STATE is registered each edge from the counter at LOOKUP_ADDR; PREDICT = PRED_STATE MSB; latency 1 cycle.
REQ-025 Bypass: if UPDATE_VALID=1 and UPDATE_ADDR=LOOKUP_ADDR on the same edge, PRED_STATE takes the post-update value, not the stale one.
REQ-026 Lookup never modifies counter state.
REQ-027 The block has no stall or backpressure; an update is accepted every cycle.

Reset
REQ-028 RESET=1 at an edge sets every counter to 2^(CTR_W-1)-1 (weakly not-taken; 1 at CTR_W=2, 0 at CTR_W=1).
REQ-029 RESET=1 drives ENABLE=0, OUT=0, PREDICT=0, and PRED_STATE=2^(CTR_W-1)-1 on the same edge.
REQ-030 RESET has priority over a coincident UPDATE_VALID; that update is discarded and produces no ENABLE pulse.
REQ-031 Reset asserted mid-sequence discards all training; the first edge after RESET falls processes inputs normally.

Verification
REQ-032 Reset, then LOOKUP_ADDR=0..7 on successive cycles -> every PRED_STATE=1, PREDICT=0, ENABLE=0.
REQ-033 UPDATE_VALID=1, ADDR=5, OUTCOME=1 for one cycle -> next cycle ENABLE=8'h20, OUT=8'h20; ADDR 5 counter=2, PREDICT=1 on lookup.
REQ-034 Four taken updates to ADDR 3, then five not-taken -> counter reads 3 after the 2nd taken and stays 3; reads 0 after the 3rd not-taken and stays 0.
REQ-035 Update ADDR 2 taken with LOOKUP_ADDR=2 on the same cycle, counter=1 -> PRED_STATE=2 and PREDICT=1 on the next cycle (bypass).
REQ-036 UPDATE_VALID=1 to ADDR 6 on the same edge as RESET=1 -> ENABLE=0, counter 6 reads 1 afterwards.
REQ-037 Parameter sweep NUM_ENTRIES=2/CTR_W=1 and NUM_ENTRIES=64/CTR_W=3 with random update/lookup traffic -> matches a reference-model scoreboard, one-hot ENABLE every cycle.
